// File: rtl/beam_sweep_scheduler.sv
// rtl/beam_sweep_scheduler.sv - steering sweep controller for the 16-mic delay-and-sum beamformer
//
// Walks the steering angle index across all angles. After each change it lets the
// delay lines refill for a few frames, then accumulates |sample| energy over a
// dwell window. At the end of a sweep it reports the loudest angle.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        level, 1 = sweep continuously; 0 = return to idle next cycle
//   sample_valid  one strobe per decimated frame
//   sample        signed beam sample, qualified by sample_valid
//   angle_idx     steering select to the delay datapath
//   angle_load    1-cycle pulse, coincident with a new angle_idx value
//   busy          1 while not idle
//   sweep_done    1-cycle pulse, coincident with updated best_idx/best_energy
//   best_idx      loudest angle of the last completed sweep
//   best_energy   dwell energy of best_idx
//
// Optional build macro BEST_HOLD_EN: after each sweep, park the steering select
// on the best angle for HOLD_FRAMES frames before starting the next sweep.

module beam_sweep_scheduler #(
    parameter int N_ANGLES      = 16,
    parameter int ANGLE_W       = 4,
    parameter int SAMPLE_W      = 16,
    parameter int SETTLE_FRAMES = 4,
    parameter int DWELL_FRAMES  = 64,
    parameter int ACC_W         = 22,
    parameter int HOLD_FRAMES   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [ANGLE_W-1:0]  angle_idx,
    output logic                angle_load,
    output logic                busy,
    output logic                sweep_done,
    output logic [ANGLE_W-1:0]  best_idx,
    output logic [ACC_W-1:0]    best_energy
);

    // One frame counter is shared by settle, dwell and hold; size it for the longest.
    localparam int CNT_MAX_SD = (SETTLE_FRAMES > DWELL_FRAMES) ? SETTLE_FRAMES : DWELL_FRAMES;
    localparam int CNT_MAX    = (HOLD_FRAMES > CNT_MAX_SD) ? HOLD_FRAMES : CNT_MAX_SD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam int SETTLE_LAST_I = (SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0;
    localparam int DWELL_LAST_I  = (DWELL_FRAMES > 0) ? DWELL_FRAMES - 1 : 0;
    localparam int HOLD_LAST_I   = (HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0;

    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_LAST_I);
    localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_LAST_I);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [ANGLE_W-1:0] LAST_ANGLE  = ANGLE_W'(N_ANGLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_CMP    = 3'd4,
        S_DONE   = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   frame_cnt;
    logic [ANGLE_W-1:0] cur_idx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   run_best_e;
    logic [ANGLE_W-1:0] run_best_i;
    logic [SAMPLE_W-1:0] mag;
    logic [ACC_W-1:0]   mag_ext;

    // Two's-complement magnitude; the most negative input maps to 2^(SAMPLE_W-1),
    // which is still representable as an unsigned SAMPLE_W-bit value.
    assign mag     = sample[SAMPLE_W-1] ? (~sample + SAMPLE_W'(1)) : sample;
    assign mag_ext = {{(ACC_W-SAMPLE_W){1'b0}}, mag};
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_LOAD;
            S_LOAD:   state_d = (SETTLE_FRAMES == 0) ? S_DWELL : S_SETTLE;
            S_SETTLE: if (sample_valid && frame_cnt == SETTLE_LAST) state_d = S_DWELL;
            S_DWELL:  if (sample_valid && frame_cnt == DWELL_LAST) state_d = S_CMP;
            S_CMP:    state_d = (cur_idx == LAST_ANGLE) ? S_DONE : S_LOAD;
`ifdef BEST_HOLD_EN
            S_DONE:   state_d = S_HOLD;
            S_HOLD:   if (sample_valid && frame_cnt == HOLD_LAST) state_d = S_LOAD;
`else
            S_DONE:   state_d = S_LOAD;
`endif
            default:  state_d = S_IDLE;
        endcase
        // Dropping enable abandons whatever is in progress.
        if (!enable) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            cur_idx     <= '0;
            acc         <= '0;
            run_best_e  <= '0;
            run_best_i  <= '0;
            angle_idx   <= '0;
            angle_load  <= 1'b0;
            sweep_done  <= 1'b0;
            best_idx    <= '0;
            best_energy <= '0;
        end else begin
            angle_load <= 1'b0;
            sweep_done <= 1'b0;
            if (!enable || state_q == S_IDLE) begin
                // Partial sweep state is discarded; reported outputs are kept.
                frame_cnt  <= '0;
                cur_idx    <= '0;
                acc        <= '0;
                run_best_e <= '0;
                run_best_i <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        angle_idx  <= cur_idx;
                        angle_load <= 1'b1;
                        frame_cnt  <= '0;
                    end
                    S_SETTLE: begin
                        if (sample_valid) begin
                            frame_cnt <= (frame_cnt == SETTLE_LAST) ? '0 : frame_cnt + CNT_W'(1);
                        end
                    end
                    S_DWELL: begin
                        if (sample_valid) begin
                            acc       <= acc + mag_ext;
                            frame_cnt <= (frame_cnt == DWELL_LAST) ? '0 : frame_cnt + CNT_W'(1);
                        end
                    end
                    S_CMP: begin
                        // Strict compare: on a tie the earlier (lower) angle stays best.
                        if (acc > run_best_e) begin
                            run_best_e <= acc;
                            run_best_i <= cur_idx;
                        end
                        acc <= '0;
                        if (cur_idx != LAST_ANGLE) cur_idx <= cur_idx + ANGLE_W'(1);
                    end
                    S_DONE: begin
                        best_idx    <= run_best_i;
                        best_energy <= run_best_e;
                        sweep_done  <= 1'b1;
                        run_best_e  <= '0;
                        run_best_i  <= '0;
                        cur_idx     <= '0;
                        frame_cnt   <= '0;
`ifdef BEST_HOLD_EN
                        angle_idx   <= run_best_i;
                        angle_load  <= 1'b1;
`endif
                    end
`ifdef BEST_HOLD_EN
                    S_HOLD: begin
                        if (sample_valid) begin
                            frame_cnt <= (frame_cnt == HOLD_LAST) ? '0 : frame_cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// tb/tb_beam_sweep_scheduler.sv - self-checking bench for beam_sweep_scheduler
module tb_beam_sweep_scheduler;

    localparam int N_ANGLES = 16;
    localparam int ANGLE_W  = 4;
    localparam int SAMPLE_W = 16;
    localparam int SETTLE   = 4;
    localparam int DWELL    = 64;
    localparam int ACC_W    = 22;
    localparam int HOLD     = 256;
    localparam int SWEEP_BUDGET = 6000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample = '0;
    logic [ANGLE_W-1:0]  angle_idx;
    logic                angle_load;
    logic                busy;
    logic                sweep_done;
    logic [ANGLE_W-1:0]  best_idx;
    logic [ACC_W-1:0]    best_energy;

    beam_sweep_scheduler #(
        .N_ANGLES(N_ANGLES), .ANGLE_W(ANGLE_W), .SAMPLE_W(SAMPLE_W),
        .SETTLE_FRAMES(SETTLE), .DWELL_FRAMES(DWELL), .ACC_W(ACC_W), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_valid(sample_valid), .sample(sample),
        .angle_idx(angle_idx), .angle_load(angle_load), .busy(busy),
        .sweep_done(sweep_done), .best_idx(best_idx), .best_energy(best_energy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Stimulus / reference model state
    int mode = 0;
    int phase = 0;
    int cur_a = 0;
    int k = 0;
    int k_at_load = 0;
    int load_a = 0;
    int energy [N_ANGLES];
    bit ev_load = 0;
    bit ev_done = 0;
    int glitches = 0;
    logic [ANGLE_W-1:0] prev_idx = '0;

    function automatic int mag_of(input logic [SAMPLE_W-1:0] s);
        int v;
        v = int'($signed(s));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [SAMPLE_W-1:0] gen(input int m, input int a, input int kk);
        int mg;
        int v;
        case (m)
            1: begin
                mg = (a == 9) ? 300 : 100;
                v = ($urandom_range(0, 1) == 1) ? mg : -mg;
            end
            2: v = ($urandom_range(0, 1) == 1) ? 50 : -50;
            3: v = (a == 3) ? -32768 : int'($urandom_range(0, 200)) - 100;
            4: v = (kk < SETTLE) ? 32767 : 0;
            default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        return SAMPLE_W'(v);
    endfunction

    // Best angle by the sweep rule: strictly larger energy wins, ties keep lower index.
    task automatic model_best(output int bi, output int be);
        bi = 0;
        be = 0;
        for (int a = 0; a < N_ANGLES; a++) begin
            if (energy[a] > be) begin
                be = energy[a];
                bi = a;
            end
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next strobe.
    // Strobes are issued every 4th cycle; the k-th strobe after an angle_load is a
    // settle frame for k < SETTLE and a dwell frame for the next DWELL strobes.
    task automatic step();
        @(negedge clk);
        ev_load = angle_load;
        ev_done = sweep_done;
        if (rst_n && angle_idx !== prev_idx && !angle_load) glitches++;
        prev_idx = angle_idx;
        if (angle_load) begin
            cur_a = int'(angle_idx);
            load_a = cur_a;
            k_at_load = k;
            k = 0;
            energy[cur_a] = 0;
        end
        phase++;
        if (phase % 4 == 0) begin
            sample = gen(mode, cur_a, k);
            sample_valid = 1'b1;
            if (k >= SETTLE && k < SETTLE + DWELL) energy[cur_a] += mag_of(sample);
            k++;
        end else begin
            sample_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ev_done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic restart(input int m);
        enable = 1'b0;
        step();
        step();
        mode = m;
        enable = 1'b1;
    endtask

    task automatic check_sweep(input string name, input int exp_i, input int exp_e);
        bit ok;
        int mi;
        int me;
        wait_done(SWEEP_BUDGET, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s timeout: no sweep_done within %0d cycles", name, SWEEP_BUDGET);
            return;
        end
        model_best(mi, me);
        tests_run++;
        if (int'(best_idx) !== mi || int'(best_energy) !== me) begin
            tests_failed++;
            $display("FAIL %s model: got idx %0d energy %0d expected idx %0d energy %0d",
                     name, best_idx, best_energy, mi, me);
        end
        if (exp_i >= 0) begin
            tests_run++;
            if (int'(best_idx) !== exp_i || int'(best_energy) !== exp_e) begin
                tests_failed++;
                $display("FAIL %s const: got idx %0d energy %0d expected idx %0d energy %0d",
                         name, best_idx, best_energy, exp_i, exp_e);
            end
        end
    endtask

    task automatic test_reset();
        bit found;
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({angle_idx, angle_load, busy, sweep_done, best_idx, best_energy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_init: got idx %0d load %0b busy %0b done %0b best %0d/%0d expected all 0",
                     angle_idx, angle_load, busy, sweep_done, best_idx, best_energy);
        end
        rst_n = 1'b1;
        mode = 1;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (ev_load && load_a == 2) begin
                found = 1;
                break;
            end
        end
        repeat (100) step();
        tests_run++;
        if (!found || busy !== 1'b1 || angle_idx !== 4'd2) begin
            tests_failed++;
            $display("FAIL reset_pre: got found %0b busy %0b idx %0d expected 1 1 2", found, busy, angle_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({angle_idx, angle_load, busy, sweep_done, best_idx, best_energy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got idx %0d load %0b busy %0b done %0b best %0d/%0d expected all 0",
                     angle_idx, angle_load, busy, sweep_done, best_idx, best_energy);
        end
        repeat (2) step();
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ev_load) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || load_a !== 0) begin
            tests_failed++;
            $display("FAIL reset_restart: got load %0b idx %0d expected load 1 idx 0", found, load_a);
        end
    endtask

    task automatic test_settle();
        restart(4);
        check_sweep("settle", 0, 0);
    endtask

    task automatic test_ties();
        restart(2);
        check_sweep("ties", 0, 50 * DWELL);
        restart(3);
        check_sweep("most_negative", 3, 32768 * DWELL);
    endtask

    task automatic test_peak();
        restart(1);
        check_sweep("peak", 9, 300 * DWELL);
    endtask

    task automatic test_enable_drop();
        bit found;
        bit done_seen;
        bit ok;
        int loads;
        restart(4);
        found = 0;
        done_seen = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            if (ev_done) done_seen = 1;
            if (ev_load && load_a == 7) begin
                found = 1;
                break;
            end
        end
        repeat (50) begin
            step();
            if (ev_done) done_seen = 1;
        end
        enable = 1'b0;
        repeat (3) begin
            step();
            if (ev_done) done_seen = 1;
        end
        tests_run++;
        if (!found || done_seen || busy !== 1'b0 || angle_idx !== 4'd7) begin
            tests_failed++;
            $display("FAIL drop_idle: got found %0b done %0b busy %0b idx %0d expected 1 0 0 7",
                     found, done_seen, busy, angle_idx);
        end
        tests_run++;
        if (best_idx !== 4'd9 || best_energy !== 22'(300 * DWELL)) begin
            tests_failed++;
            $display("FAIL drop_retain: got best %0d/%0d expected 9/%0d", best_idx, best_energy, 300 * DWELL);
        end
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ev_load) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || load_a !== 0) begin
            tests_failed++;
            $display("FAIL drop_restart: got load %0b idx %0d expected load 1 idx 0", found, load_a);
        end
        loads = 1;
        ok = 0;
        for (int i = 0; i < SWEEP_BUDGET; i++) begin
            step();
            if (ev_load) loads++;
            if (ev_done) begin
                ok = 1;
                break;
            end
        end
        tests_run++;
        if (!ok || loads !== N_ANGLES || best_idx !== 4'd0 || best_energy !== '0) begin
            tests_failed++;
            $display("FAIL drop_full_sweep: got done %0b loads %0d best %0d/%0d expected 1 %0d 0/0",
                     ok, loads, best_idx, best_energy, N_ANGLES);
        end
    endtask

    task automatic test_back_to_back();
        restart(0);
        check_sweep("random_a", -1, 0);
        check_sweep("random_b", -1, 0);
    endtask

    task automatic test_hold();
        bit found;
        int b;
        int cyc;
        b = int'(best_idx);
        found = 0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cyc++;
            if (ev_load) begin
                found = 1;
                break;
            end
        end
`ifdef BEST_HOLD_EN
        tests_run++;
        if (!found || load_a !== b || cyc !== 1) begin
            tests_failed++;
            $display("FAIL hold_park: got load %0b idx %0d after %0d cycles expected idx %0d after 1",
                     found, load_a, cyc, b);
        end
        found = 0;
        for (int i = 0; i < HOLD * 4 + 50; i++) begin
            step();
            if (ev_load) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || load_a !== 0 || k_at_load !== HOLD) begin
            tests_failed++;
            $display("FAIL hold_release: got load %0b idx %0d strobes %0d expected idx 0 strobes %0d",
                     found, load_a, k_at_load, HOLD);
        end
`else
        tests_run++;
        if (!found || load_a !== 0 || cyc !== 1) begin
            tests_failed++;
            $display("FAIL no_hold_restart: got load %0b idx %0d after %0d cycles expected idx 0 after 1 (best %0d)",
                     found, load_a, cyc, b);
        end
`endif
        tests_run++;
        if (glitches !== 0) begin
            tests_failed++;
            $display("FAIL angle_stable: got %0d changes without angle_load expected 0", glitches);
        end
    endtask

    initial begin
        for (int a = 0; a < N_ANGLES; a++) energy[a] = 0;
        test_reset();
        test_settle();
        test_ties();
        test_peak();
        test_enable_drop();
        test_back_to_back();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
